// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Build option: define MULDIV_DIV_EN to compile in the DIV state and the divider datapath.
package muldiv_pkg;

  // Operation encoding as presented on the op input.
  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StFin  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StFin  = 2'd3
  } state_e;
`endif

  localparam int unsigned ITER_COUNT = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFFFFFF;

  // Magnitude of a 32-bit operand; only negative values of signed ops are negated.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: add-shift for multiply, trial-subtract for divide.
// Build option: MULDIV_DIV_EN adds the divide path and the div select input.
// work layout: multiply {partial product, remaining multiplier}; divide {remainder, dividend}.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic        div,
`endif
  input  logic [63:0] work,
  input  logic [31:0] operand,
  output logic [63:0] work_next
);

  logic [32:0] sum;
  logic [63:0] mul_next;
`ifdef MULDIV_DIV_EN
  logic [31:0] diff;
  logic        fits;
  logic [63:0] div_next;
`endif

  // Single combinational iteration for whichever operation is running.
  always_comb begin
    sum      = {1'b0, work[63:32]} + {1'b0, operand};
    mul_next = work[0] ? {sum, work[31:1]} : {1'b0, work[63:1]};
`ifdef MULDIV_DIV_EN
    // Trial value is {remainder, next dividend bit}; bit 63 set means it exceeds any divisor.
    diff     = work[62:31] - operand;
    fits     = work[63] | (work[62:31] >= operand);
    div_next = fits ? {diff, work[30:0], 1'b1} : {work[62:31], work[30:0], 1'b0};
    work_next = div ? div_next : mul_next;
`else
    work_next = mul_next;
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Build option: MULDIV_DIV_EN compiles in DIV/DIVU; without it those ops finish at once with
// no effect on HI/LO.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] LastIter = 5'(ITER_COUNT - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d, step_next;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_res_q, neg_res_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        load, finish;
  op_e         op_cur;
  logic        op_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod;
`ifdef MULDIV_DIV_EN
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] quo, rem;
`endif

  // Operand sign handling at accept time.
  always_comb begin
    op_cur    = op_e'(op);
    op_signed = (op_cur == OpMult) || (op_cur == OpDiv);
    a_neg     = op_signed & rs_val[31];
    b_neg     = op_signed & rt_val[31];
    mag_a     = mag32(rs_val, op_signed);
    mag_b     = mag32(rt_val, op_signed);
  end

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .div       (state_q == StDiv),
`endif
    .work      (work_q),
    .operand   (opnd_q),
    .work_next (step_next)
  );

  // Control FSM: accept from IDLE/FIN, iterate 32 times, then pulse FIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      StIdle, StFin: begin
        cnt_d = '0;
        if (start) begin
          load = 1'b1;
          if (op[1]) begin
`ifdef MULDIV_DIV_EN
            state_d = StDiv;
`else
            state_d = StFin;
`endif
          end else begin
            state_d = StMul;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StMul: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = StFin;
          finish  = 1'b1;
        end
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = StFin;
          finish  = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
`ifdef MULDIV_DIV_EN
    busy = (state_q == StMul) || (state_q == StDiv);
`else
    busy = (state_q == StMul);
`endif
    done = (state_q == StFin);
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath next state: load magnitudes on accept, iterate while busy.
  always_comb begin
    work_d    = work_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
`ifdef MULDIV_DIV_EN
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    dvd_d     = dvd_q;
`endif
    if (load) begin
      work_d    = {32'd0, mag_a};
      opnd_d    = mag_b;
      neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
      neg_rem_d = a_neg;
      div0_d    = (rt_val == 32'd0);
      dvd_d     = rs_val;
`endif
    end else if (busy) begin
      work_d = step_next;
    end
  end

  // Final sign fix-up is taken from the last iteration so HI/LO update on FIN entry.
  always_comb begin
    prod = neg_res_q ? (~step_next + 64'd1) : step_next;
`ifdef MULDIV_DIV_EN
    quo  = neg_res_q ? (~step_next[31:0] + 32'd1) : step_next[31:0];
    rem  = neg_rem_q ? (~step_next[63:32] + 32'd1) : step_next[63:32];
`endif
    hi_d = hi_q;
    lo_d = lo_q;
    if (finish) begin
`ifdef MULDIV_DIV_EN
      if (state_q == StDiv) begin
        if (div0_q) begin
          lo_d = DIV0_LO;
          hi_d = dvd_q;
        end else begin
          lo_d = quo;
          hi_d = rem;
        end
      end else begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end
`else
      hi_d = prod[63:32];
      lo_d = prod[31:0];
`endif
    end else if (mt_we && !busy) begin
      if (mt_sel) hi_d = mt_data;
      else        lo_d = mt_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      dvd_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      dvd_q     <= dvd_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: fixed vector table, corner sequences, random ops.
// Build option: MULDIV_DIV_EN selects whether DIV/DIVU are expected to compute or to no-op.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, mt_we, mt_sel;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, mt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mt_we   (mt_we),
    .mt_sel  (mt_sel),
    .mt_data (mt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic [1:0]  noise;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp_v);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Start one op and follow it to its done pulse.
  // noise: 1 = start held mid-op, 2 = MTLO 0xAA mid-op, 3 = MTLO 0x77 on the accept edge.
  task automatic run_op(input logic [1:0] op_v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm,
                        input int noise);
    int k;
    bit seen, busy_ok;
    start  = 1'b1;
    op     = op_v;
    rs_val = a;
    rt_val = b;
    if (noise == 3) begin
      mt_we   = 1'b1;
      mt_sel  = 1'b0;
      mt_data = 32'h77;
    end
    tick();
    start  = 1'b0;
    mt_we  = 1'b0;
    op     = 2'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
    if (noise == 3) begin
      check({nm, " mt same edge lo"}, lo, 32'h77);
      m_lo = 32'h77;
    end
`ifndef MULDIV_DIV_EN
    if (op_v[1]) begin
      check({nm, " nodiv done"}, done, 1);
      check({nm, " nodiv busy"}, busy, 0);
      check({nm, " nodiv hi"}, hi, m_hi);
      check({nm, " nodiv lo"}, lo, m_lo);
      return;
    end
`endif
    busy_ok = 1'b1;
    seen    = 1'b0;
    k       = 1;
    while (!seen && k <= 40) begin
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        start   = (noise == 1) && (k >= 4) && (k <= 10);
        mt_we   = (noise == 2) && (k == 5);
        mt_sel  = 1'b0;
        mt_data = 32'hAA;
        tick();
        k++;
      end
    end
    start = 1'b0;
    mt_we = 1'b0;
    check({nm, " done seen"}, seen, 1);
    check({nm, " latency"}, k, 33);
    check({nm, " busy span"}, busy_ok, 1);
    check({nm, " busy at done"}, busy, 0);
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int d1, d2, ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb, eh, el;
    reset = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0;
    m_hi = '0; m_lo = '0;

    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 2'd0};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2'd1};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 2'd0};
    vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 2'd0};
    vecs[4] = '{2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 2'd0};
    vecs[5] = '{2'b01, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 2'd2};
    vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 2'd0};
    vecs[7] = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 2'd0};
    vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2'd0};
    vecs[9] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 2'd0};

    tick();
    tick();
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);

    // MTHI in IDLE lands on the next edge.
    mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'h55;
    tick();
    mt_we = 1'b0;
    check("mthi hi", hi, 32'h55);
    check("mthi lo", lo, 0);
    m_hi = 32'h55;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
             $sformatf("vec%0d", i), int'(vecs[i].noise));
      tick();
      check($sformatf("vec%0d done pulse", i), done, 0);
      check($sformatf("vec%0d idle busy", i), busy, 0);
    end

    run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "mt+start", 3);

    // Back-to-back accept from FIN.
    run_op(2'b00, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA, "b2b first", 0);
    d1 = cyc;
    run_op(2'b01, 32'd100, 32'd200, 32'd0, 32'd20000, "b2b second", 0);
    d2 = cyc;
    check("b2b spacing", d2 - d1, 33);

    // Reset ten edges into an op, while also requesting start and an MT write.
    tick();
    start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1; start = 1'b1; mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hDEAD;
    tick();
    reset = 1'b0; start = 1'b0; mt_we = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    m_hi = '0; m_lo = '0;
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    check("abort hi held", hi, 0);
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "after abort", 0);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 9);
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, eh, el, $sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), 0);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check($sformatf("rnd%0d idle done", i), done, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
